// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit common-anode seven-segment driver with per-slot dead time,
// per-frame digit snapshot, minus-sign rendering and optional leading-zero blanking.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DEAD_CYC    = 500,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] DEAD_LAST    = CW'(DEAD_CYC - 1);
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSnap,
        StBlank,
        StDrive
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           idx_q, idx_d;
    logic [3:0][3:0]      snap_q, snap_d;
    logic                 tick_q, tick_d;
    logic [3:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic [3:0]           lz_blank;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hF:    s = 7'h3F;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // A minus sign in thousands is non-zero, so it naturally keeps lower zeros lit.
    always_comb begin
        lz_blank    = 4'b0000;
        lz_blank[3] = LZ_BLANK && (snap_q[3] == 4'h0);
        lz_blank[2] = lz_blank[3] && (snap_q[2] == 4'h0);
        lz_blank[1] = lz_blank[2] && (snap_q[1] == 4'h0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        tick_d  = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = 2'd0;
                if (en) begin
                    state_d = StSnap;
                end
            end
            StSnap: begin
                snap_d  = {thousands, hundreds, tens, ones};
                tick_d  = 1'b1;
                cnt_d   = '0;
                idx_d   = 2'd0;
                state_d = StBlank;
            end
            StBlank: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == DEAD_LAST) begin
                    state_d = StDrive;
                end
            end
            StDrive: begin
                if (cnt_q == REFRESH_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 2'd3) begin
                        state_d = StSnap;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = StBlank;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                idx_d   = 2'd0;
            end
        endcase

        // Disable always wins and discards any frame in progress.
        if (!en && (state_q != StIdle)) begin
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = 2'd0;
            snap_d  = snap_q;
            tick_d  = 1'b0;
        end
    end

    always_comb begin
        an_d  = 4'hF;
        seg_d = 7'h7F;
        if (state_q == StDrive) begin
            an_d[idx_q] = 1'b0;
            seg_d       = lz_blank[idx_q] ? 7'h7F : decode(snap_q[idx_q]);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            snap_q  <= '0;
            tick_q  <= 1'b0;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            tick_q  <= tick_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = 1'b1;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed and random checks of seg7_scan_driver against a frame-position model;
// two instances cover leading-zero blanking on and off.
module tb_seg7_scan_driver;

    localparam int unsigned R     = 8;
    localparam int unsigned D     = 2;
    localparam int          FRAME = 4 * R + 1;

    logic       clk = 1'b0;
    logic       clr;
    logic       en;
    logic [3:0] ones, tens, hundreds, thousands;
    logic [3:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b, ft_a, ft_b;

    always #5 clk = ~clk;

    seg7_scan_driver #(.REFRESH_DIV(R), .DEAD_CYC(D), .LZ_BLANK(1'b1)) dut_a (
        .clk(clk), .clr(clr), .en(en), .ones(ones), .tens(tens), .hundreds(hundreds),
        .thousands(thousands), .an(an_a), .seg(seg_a), .dp(dp_a), .frame_tick(ft_a)
    );

    seg7_scan_driver #(.REFRESH_DIV(R), .DEAD_CYC(D), .LZ_BLANK(1'b0)) dut_b (
        .clk(clk), .clr(clr), .en(en), .ones(ones), .tens(tens), .hundreds(hundreds),
        .thousands(thousands), .an(an_b), .seg(seg_b), .dp(dp_b), .frame_tick(ft_b)
    );

    int         n_pass  = 0;
    int         n_total = 0;
    int         cycle   = 0;
    int         pos     = -1;   // model: frame position of the state now held, -1 = idle
    logic [3:0] m_snap [4];
    logic [6:0] seg_tab [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cycle, obs, exp);
    endtask

    // Blank a digit when the whole value is too small to reach it.
    function automatic logic [6:0] model_seg(input int slot, input bit lz);
        int value;
        if (lz && m_snap[3] != 4'hF && slot > 0) begin
            value = m_snap[3] * 1000 + m_snap[2] * 100 + m_snap[1] * 10 + m_snap[0];
            if (value < 10 ** slot) return 7'h7F;
        end
        return seg_tab[m_snap[slot]];
    endfunction

    task automatic cyc();
        logic [3:0] e_an;
        logic [6:0] e_seg_a, e_seg_b;
        logic       e_tick;
        int         k;
        e_an    = 4'hF;
        e_seg_a = 7'h7F;
        e_seg_b = 7'h7F;
        e_tick  = 1'b0;
        if (clr) begin
            pos = -1;
            for (int i = 0; i < 4; i++) m_snap[i] = 4'h0;
        end else begin
            if (pos > 0) begin
                k = pos - 1;
                if (k % R >= D) begin
                    e_an[k / R] = 1'b0;
                    e_seg_a     = model_seg(k / R, 1'b1);
                    e_seg_b     = model_seg(k / R, 1'b0);
                end
            end
            if (pos == 0 && en) begin
                e_tick    = 1'b1;
                m_snap[0] = ones;
                m_snap[1] = tens;
                m_snap[2] = hundreds;
                m_snap[3] = thousands;
            end
            if (!en) pos = -1;
            else if (pos == -1) pos = 0;
            else pos = (pos + 1) % FRAME;
        end
        @(posedge clk);
        #1;
        cycle++;
        chk("an_lz1", 32'(an_a), 32'(e_an));
        chk("seg_lz1", 32'(seg_a), 32'(e_seg_a));
        chk("tick_lz1", 32'(ft_a), 32'(e_tick));
        chk("dp_lz1", 32'(dp_a), 32'd1);
        chk("an_lz0", 32'(an_b), 32'(e_an));
        chk("seg_lz0", 32'(seg_b), 32'(e_seg_b));
        chk("tick_lz0", 32'(ft_b), 32'(e_tick));
        chk("dp_lz0", 32'(dp_b), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic set_digits(input logic [3:0] th, hu, te, on);
        thousands = th;
        hundreds  = hu;
        tens      = te;
        ones      = on;
    endtask

    task automatic wait_tick(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (ft_a) begin
                at = cycle;
                break;
            end
        end
        if (at < 0) chk("wait_tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_to_pos(input int target, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (pos == target) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) chk("run_to_pos_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int t1, t2, lat;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F};
        for (int i = 0; i < 4; i++) m_snap[i] = 4'h0;

        // Reset held with en high, then release
        clr = 1'b1;
        en  = 1'b1;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        run(3);
        chk("reset_an", 32'(an_a), 32'hF);
        chk("reset_seg", 32'(seg_a), 32'h7F);
        chk("reset_tick", 32'(ft_a), 32'd0);
        clr = 1'b0;
        run(1);
        chk("tick_after_release", 32'(ft_a), 32'd0);
        run(1);
        chk("tick_after_snap", 32'(ft_a), 32'd1);
        t1 = cycle;

        // Steady scan of 1234 and frame period
        wait_tick(2 * FRAME, t2);
        chk("frame_period", 32'(t2 - t1), 32'(FRAME));
        run(FRAME);

        // Minus sign keeps lower zeros
        set_digits(4'hF, 4'd0, 4'd0, 4'd5);
        run(2 * FRAME);

        // All zeros: blanking differs between the two instances
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        run(2 * FRAME);

        // Mid-frame change must not tear the current frame
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        wait_tick(2 * FRAME, t1);
        run_to_pos(1 + R + D + 1, 2 * FRAME);
        ones = 4'd9;
        run(2 * FRAME);

        // Disable during the hundreds slot, then restart
        run_to_pos(1 + 2 * R + D + 2, 2 * FRAME);
        en = 1'b0;
        run(2);
        chk("dark_after_disable", 32'(an_a), 32'hF);
        run(2);
        en  = 1'b1;
        lat = -1;
        for (int i = 1; i <= 4 * R; i++) begin
            cyc();
            if (an_a != 4'hF) begin
                lat = i;
                break;
            end
        end
        chk("restart_first_an", 32'(an_a), 32'hE);
        chk("restart_latency", 32'(lat), 32'(3 + D));
        run(FRAME);

        // Random digits, enable toggles and occasional reset
        for (int i = 0; i < 400; i++) begin
            clr = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) == 0) begin
                t1 = $urandom_range(0, 10);
                thousands = (t1 == 10) ? 4'hF : 4'(t1);
                hundreds  = 4'($urandom_range(0, 9));
                tens      = 4'($urandom_range(0, 9));
                ones      = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 59) == 0) en = ~en;
            cyc();
        end
        clr = 1'b0;
        en  = 1'b1;
        run(FRAME);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
